// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, device-clocked shift, parity, ACK check.
// Optional: define PS2_TX_RETRY_EN to retry a failed transfer up to twice before flagging tx_error.
module ps2_host_tx #(
  parameter int unsigned DATA_WIDTH     = 8,
  parameter int unsigned INHIBIT_CYCLES = 5000,
  parameter int unsigned TIMEOUT_CYCLES = 750000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] tx_data,
  input  logic                  tx_start,
  output logic                  tx_busy,
  output logic                  tx_done,
  output logic                  tx_error,
  input  logic                  ps2_clk_in,
  input  logic                  ps2_data_in,
  output logic                  ps2_clk_oe,
  output logic                  ps2_data_oe
);

  localparam int unsigned CntMax = (INHIBIT_CYCLES > TIMEOUT_CYCLES) ? INHIBIT_CYCLES
                                                                     : TIMEOUT_CYCLES;
  localparam int unsigned CntW   = $clog2(CntMax + 1);
  localparam int unsigned IdxW   = $clog2(DATA_WIDTH);

  localparam logic [CntW-1:0] InhibitLast = CntW'(INHIBIT_CYCLES - 1);
  localparam logic [CntW-1:0] TimeoutCnt  = CntW'(TIMEOUT_CYCLES);
  localparam logic [IdxW-1:0] IdxLast     = IdxW'(DATA_WIDTH - 1);

  typedef enum logic [3:0] {
    StIdle,
    StInhibit,
    StReq,
    StStart,
    StData,
    StParity,
    StStop,
    StRelease,
    StDone,
    StErr
  } state_e;

  state_e                state;
  logic [CntW-1:0]       cnt;
  logic [IdxW-1:0]       idx;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                  par;

  // Line synchronisers; idle lines are high, so reset to 1 to avoid a phantom fall.
  logic clk_s1, clk_s2, clk_h;
  logic dat_s1, dat_s2;
  logic fall;

  always_ff @(posedge clk) begin
    if (reset) begin
      clk_s1 <= 1'b1;
      clk_s2 <= 1'b1;
      clk_h  <= 1'b1;
      dat_s1 <= 1'b1;
      dat_s2 <= 1'b1;
    end else begin
      clk_s1 <= ps2_clk_in;
      clk_s2 <= clk_s1;
      clk_h  <= clk_s2;
      dat_s1 <= ps2_data_in;
      dat_s2 <= dat_s1;
    end
  end

  assign fall = clk_h & ~clk_s2;

  logic in_window;
  logic timed_out;
  logic nack;
  logic fail;
  logic retry;

  assign in_window = state inside {StStart, StData, StParity, StStop, StRelease};
  assign timed_out = in_window && (cnt == TimeoutCnt);
  assign nack      = (state == StStop) && fall && dat_s2;
  assign fail      = timed_out | nack;

`ifdef PS2_TX_RETRY_EN
  logic [1:0] retry_cnt;
  assign retry = fail && (retry_cnt != 2'd2);
`else
  assign retry = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= StIdle;
      cnt         <= '0;
      idx         <= '0;
      tx_byte     <= '0;
      par         <= 1'b0;
      tx_busy     <= 1'b0;
      tx_done     <= 1'b0;
      tx_error    <= 1'b0;
      ps2_clk_oe  <= 1'b0;
      ps2_data_oe <= 1'b0;
`ifdef PS2_TX_RETRY_EN
      retry_cnt   <= 2'd0;
`endif
    end else begin
      tx_done  <= 1'b0;
      tx_error <= 1'b0;
      // Timeout and NACK share one abort path and win over any concurrent fall.
      if (fail) begin
        cnt         <= '0;
        ps2_data_oe <= 1'b0;
        if (retry) begin
          state      <= StInhibit;
          ps2_clk_oe <= 1'b1;
`ifdef PS2_TX_RETRY_EN
          retry_cnt  <= retry_cnt + 2'd1;
`endif
        end else begin
          state      <= StErr;
          ps2_clk_oe <= 1'b0;
          tx_error   <= 1'b1;
        end
      end else begin
        unique case (state)
          StIdle: begin
            if (tx_start) begin
              tx_byte     <= tx_data;
              par         <= ~^tx_data;
              cnt         <= '0;
              tx_busy     <= 1'b1;
              ps2_clk_oe  <= 1'b1;
              ps2_data_oe <= 1'b0;
              state       <= StInhibit;
`ifdef PS2_TX_RETRY_EN
              retry_cnt   <= 2'd0;
`endif
            end
          end
          StInhibit: begin
            if (cnt == InhibitLast) begin
              cnt         <= '0;
              ps2_data_oe <= 1'b1;
              state       <= StReq;
            end else begin
              cnt <= cnt + CntW'(1);
            end
          end
          StReq: begin
            // Start bit stays low while the clock is released to the device.
            ps2_clk_oe <= 1'b0;
            cnt        <= '0;
            state      <= StStart;
          end
          StStart: begin
            cnt <= cnt + CntW'(1);
            if (fall) begin
              ps2_data_oe <= ~tx_byte[0];
              idx         <= '0;
              state       <= StData;
            end
          end
          StData: begin
            cnt <= cnt + CntW'(1);
            if (fall) begin
              if (idx == IdxLast) begin
                ps2_data_oe <= ~par;
                state       <= StParity;
              end else begin
                ps2_data_oe <= ~tx_byte[idx + IdxW'(1)];
                idx         <= idx + IdxW'(1);
              end
            end
          end
          StParity: begin
            cnt <= cnt + CntW'(1);
            if (fall) begin
              ps2_data_oe <= 1'b0;
              state       <= StStop;
            end
          end
          StStop: begin
            cnt <= cnt + CntW'(1);
            if (fall) begin
              state <= StRelease;
            end
          end
          StRelease: begin
            cnt <= cnt + CntW'(1);
            if (clk_s2 && dat_s2) begin
              tx_done <= 1'b1;
              state   <= StDone;
            end
          end
          StDone: begin
            tx_busy <= 1'b0;
            state   <= StIdle;
          end
          StErr: begin
            tx_busy <= 1'b0;
            state   <= StIdle;
          end
          default: begin
            state <= StIdle;
          end
        endcase
      end
    end
  end

endmodule

// File: doc/ps2_host_tx.md
Name: ps2_host_tx

Overview:
- Host-to-device PS/2 transmitter. Sends one command byte to the keyboard, e.g. 0xED set-LEDs or 0xFF reset.
- Companion to the existing PS/2 receive path; both share the same open-drain PS/2 clock and data lines.
- Handles the full host request sequence: inhibit, request-to-send, device-clocked bit shifting, odd parity, stop bit, device ACK check, and a watchdog timeout.
- Sits between the bus-side register logic and the pad-level open-drain drivers.

Parameters:
- DATA_WIDTH, 8: command byte width. Only the value 8 is supported.
- INHIBIT_CYCLES, 5000: clk cycles the host holds PS/2 clock low before the request (100 us at 50 MHz).
- TIMEOUT_CYCLES, 750000: maximum clk cycles from clock release to ACK-line-release before abort (15 ms at 50 MHz).

Ports:
- clk  in  1  system clock. Single clock domain.
- reset  in  1  synchronous, active-high reset.
- tx_data  in  8  command byte; sampled when tx_start is accepted.
- tx_start  in  1  one-cycle request. Accepted only while tx_busy=0.
- tx_busy  out  1  high from the cycle after acceptance until the return to IDLE.
- tx_done  out  1  one-cycle pulse: byte sent and device ACKed.
- tx_error  out  1  one-cycle pulse: NACK or timeout.
- ps2_clk_in  in  1  raw PS/2 clock pin (asynchronous).
- ps2_data_in  in  1  raw PS/2 data pin (asynchronous).
- ps2_clk_oe  out  1  1 = drive PS/2 clock low; 0 = release.
- ps2_data_oe  out  1  1 = drive PS/2 data low; 0 = release.

Behaviour:
- Input synchronisation:
  - ps2_clk_in and ps2_data_in each pass through a 2-flop synchroniser, then one history flop.
  - fall = history & ~sync_clk. fall is seen 3 clk cycles after the pin edge.
- Outputs: all registered.
  - Reset values: tx_busy=0, tx_done=0, tx_error=0, ps2_clk_oe=0, ps2_data_oe=0.
  - State=IDLE and all counters cleared.
- Acceptance: tx_start & IDLE latches tx_data into the shift register and the odd parity bit, par = ~^tx_data. Next state is INHIBIT.
- tx_start while busy: ignored. No queueing, no error.
- Driving a data bit: a bit value b is driven as ps2_data_oe = ~b.
- State machine:
  - IDLE: both lines released. Waits for tx_start.
  - INHIBIT: clk_oe=1, data_oe=0 for exactly INHIBIT_CYCLES cycles.
  - REQ: clk_oe=1, data_oe=1 for 1 cycle. This is the start bit, driven low while the clock is still held.
  - START: clk_oe=0, data_oe=1. The timeout counter starts here. On fall: drive bit0, idx=0, go to DATA.
  - DATA: on fall:
    - idx<7: drive bit idx+1, idx++.
    - idx==7: drive par, go to PARITY.
  - PARITY: on fall: data_oe=0 (stop bit = 1), go to STOP.
  - STOP: on fall, sample synced data:
    - 0 (ACK): go to RELEASE.
    - 1 (NACK): go to ERR.
  - RELEASE: wait until synced clk=1 and data=1 in the same cycle, then go to DONE.
  - DONE: tx_done=1 for 1 cycle, then IDLE.
  - ERR: clk_oe=0, data_oe=0, tx_error=1 for 1 cycle, then IDLE.
- Timeout:
  - The counter runs in START through RELEASE.
  - Reaching TIMEOUT_CYCLES in any of those states forces ERR on the next cycle. This takes priority over a simultaneous fall.
- tx_busy = 1 in every state except IDLE.
- tx_done and tx_error are never asserted in the same cycle.
- Reset mid-operation: on the next clk edge both oe outputs go to 0, state goes to IDLE, and no done/error pulse is produced. The latched byte is discarded.
- Spurious fall in IDLE, INHIBIT or REQ: ignored.

Optional Feature:
- Macro: PS2_TX_RETRY_EN.
- Defined:
  - On NACK or timeout, the FSM returns to INHIBIT with the same latched byte and parity.
  - Up to 2 retries (3 attempts total).
  - tx_error pulses only after the third failure. tx_busy stays high throughout.
  - The retry counter clears on acceptance and on reset.
- Undefined: a single attempt. The first NACK or timeout goes to ERR.

Test Plan:
- Send 0xED, with a device model clocking at 12.5 kHz and ACKing.
  - Start bit: data_oe=1.
  - Bits LSB-first, sampled at each device rising edge: 1,0,1,1,0,1,1,1, i.e. data_oe 0,1,0,0,1,0,0,0.
  - Parity=0 (data_oe=1); stop bit: data_oe=0.
  - tx_done pulses exactly once after both lines are high. tx_error=0.
- Send 0x00: parity bit=1 (data_oe=0 at the parity slot).
  - Verify ps2_clk_oe=1 for exactly INHIBIT_CYCLES+1 cycles after acceptance.
- Device NACK (data high at the 11th fall), macro undefined: tx_error pulses 1 cycle, tx_done=0, both oe=0, tx_busy=0 afterwards.
- Device never clocks, TIMEOUT_CYCLES=1000: tx_error fires 1001 cycles after entering START.
  - With PS2_TX_RETRY_EN: 3 inhibit phases are observed before a single tx_error.
- Reset asserted mid-DATA (idx=3): both oe=0 and tx_busy=0 one cycle later, no pulses.
  - A new tx_start=0xFF then completes normally.
- tx_start=0x55 pulsed while busy sending 0xF4: the byte on the wire is 0xF4, with exactly one tx_done.
